// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline reset sequencer.
//   state_e  : sequencer FSM states (HOLD, RELEASE, RUN)
//   stage_e  : pipeline stage index, bit k of stage_rst resets stage k
//   DEF_*    : default parameter values used by the sequencer top
package pipe_pkg;

  typedef enum logic [1:0] {
    HOLD,
    RELEASE,
    RUN
  } state_e;

  typedef enum int unsigned {
    IF  = 0,
    ID  = 1,
    EX  = 2,
    MEM = 3,
    WB  = 4
  } stage_e;

  localparam int DEF_STAGES      = 5;
  localparam int DEF_HOLD_CYCLES = 4;
  localparam int DEF_GAP         = 1;
  localparam int DEF_CNT_W       = 32;

endpackage

// File: rtl/reset_sync.sv
// Two-flop reset synchronizer: asserts asynchronously, deasserts on the
// second rising clock edge after the raw reset falls.
//   clk_i   : destination clock
//   rst_i   : raw reset, asynchronous, active-high
//   rst_s_o : synchronized reset, active-high
module reset_sync (
  input  logic clk_i,
  input  logic rst_i,
  output logic rst_s_o
);

  logic [1:0] sync_q;

  // NOTE: the async set makes even a sub-cycle rst pulse land in both flops,
  // so a glitch always produces a full two-edge deassertion.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b11;
    end else begin
      // NOTE: non-blocking so both flops sample their old values on the same edge.
      sync_q <= {sync_q[0], 1'b0};
    end
  end

  assign rst_s_o = sync_q[1];

endmodule

// File: rtl/pipe_reset_sequencer.sv
// Staged pipeline reset release. After the raw reset is synchronized and held
// for HOLD_CYCLES edges, stage resets are released from WB (highest bit) down
// to IF (bit 0), GAP+1 edges apart. One edge after IF is released the block
// enters RUN and counts run-time edges with a saturating counter.
//   clk       : single clock
//   rst       : raw reset, asynchronous, active-high
//   stage_rst : per-stage reset, active-high, bit k resets stage k
//   run       : high once every stage is released
//   busy      : high while holding or releasing
//   cycle_cnt : saturating count of edges spent in RUN
module pipe_reset_sequencer
  import pipe_pkg::*;
#(
  parameter int STAGES      = DEF_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int GAP         = DEF_GAP,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic [STAGES-1:0] stage_rst,
  output logic              run,
  output logic              busy,
  output logic [CNT_W-1:0]  cycle_cnt
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int GAP_W  = $clog2(GAP + 2);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP);

  logic rst_s;

  state_e             state_q,     state_d;
  logic [HOLD_W-1:0]  hold_q,      hold_d;
  logic [GAP_W-1:0]   gap_q,       gap_d;
  logic [STAGES-1:0]  stage_rst_q, stage_rst_d;
  logic               run_q,       run_d;
  logic               busy_q,      busy_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;

  reset_sync u_reset_sync (
    .clk_i   (clk),
    .rst_i   (rst),
    .rst_s_o (rst_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HOLD;
      hold_q      <= '0;
      gap_q       <= '0;
      stage_rst_q <= '1;
      run_q       <= 1'b0;
      busy_q      <= 1'b1;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      gap_q       <= gap_d;
      stage_rst_q <= stage_rst_d;
      run_q       <= run_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets its hold value first so no branch can infer a latch.
    state_d     = state_q;
    hold_d      = hold_q;
    gap_d       = gap_q;
    stage_rst_d = stage_rst_q;
    cnt_d       = cnt_q;

    case (state_q)
      HOLD: begin
        if (rst_s) begin
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          // Released bits always form a cleared top segment, so a right shift
          // clears exactly the highest stage still held.
          stage_rst_d = stage_rst_q >> 1;
          gap_d       = '0;
          state_d     = RELEASE;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      RELEASE: begin
        // IF was released on the previous edge: enter RUN one edge later.
        if (stage_rst_q == '0) begin
          state_d = RUN;
        end else if (gap_q == GAP_LAST) begin
          stage_rst_d = stage_rst_q >> 1;
          gap_d       = '0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      RUN: begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = HOLD;
      end
    endcase

    // Flag registers follow the next state so they change on the same edge.
    run_d  = (state_d == RUN);
    busy_d = (state_d != RUN);
  end

  assign stage_rst = stage_rst_q;
  assign run       = run_q;
  assign busy      = busy_q;
  assign cycle_cnt = cnt_q;

endmodule
